// File: rtl/mem_port_arbiter.sv
// Two-requester (IF fetch, MEM load/store) arbiter for one DataMemory port; valid at WAIT_CYCLES+1 after grant request.
// Requesters are held off by combinational stalls; define ARB_ROUND_ROBIN_EN for alternating grants under contention.
module mem_port_arbiter #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              mem_req,
   input  logic              mem_rw,
   input  logic [1:0]        mem_size,
   input  logic              mem_se,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_valid,
   output logic              mem_stall,
   output logic              port_e,
   output logic              port_rw,
   output logic [1:0]        port_size,
   output logic              port_se,
   output logic [ADDR_W-1:0] port_a,
   output logic [DATA_W-1:0] port_di,
   input  logic [DATA_W-1:0] port_do
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

   localparam logic       SRC_IF   = 1'b0;
   localparam logic       SRC_MEM  = 1'b1;
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic                last_src_q;
   logic                port_e_q, port_rw_q, port_se_q;
   logic [1:0]          port_size_q;
   logic [ADDR_W-1:0]   port_a_q;
   logic [DATA_W-1:0]   port_di_q;
   logic                if_valid_q, mem_valid_q;
   logic [DATA_W-1:0]   if_rdata_q, mem_rdata_q;

   logic if_qual, mem_qual, pick_mem, grant_mem, grant_if;

   // A requester is masked during its own valid cycle so a held req is not re-served.
   assign if_qual  = if_req  & ~if_valid_q;
   assign mem_qual = mem_req & ~mem_valid_q;

`ifdef ARB_ROUND_ROBIN_EN
   assign pick_mem = (last_src_q == SRC_IF);
`else
   assign pick_mem = last_src_q | 1'b1;
`endif

   assign grant_mem = mem_qual & (~if_qual | pick_mem);
   assign grant_if  = if_qual & ~grant_mem;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_src_q  <= SRC_MEM;
         port_e_q    <= 1'b0;
         port_rw_q   <= 1'b0;
         port_size_q <= 2'b00;
         port_se_q   <= 1'b0;
         port_a_q    <= '0;
         port_di_q   <= '0;
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_mem) begin
                  state_q     <= BUSY_MEM;
                  cnt_q       <= CNT_INIT;
                  port_e_q    <= 1'b1;
                  port_rw_q   <= mem_rw;
                  port_size_q <= mem_size;
                  port_se_q   <= mem_se;
                  port_a_q    <= mem_addr;
                  port_di_q   <= mem_wdata;
               end else if (grant_if) begin
                  state_q     <= BUSY_IF;
                  cnt_q       <= CNT_INIT;
                  port_e_q    <= 1'b1;
                  port_rw_q   <= 1'b0;
                  port_size_q <= 2'b10;
                  port_se_q   <= 1'b0;
                  port_a_q    <= if_addr;
                  port_di_q   <= '0;
               end
            end
            BUSY_IF: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  if_rdata_q <= port_do;
                  if_valid_q <= 1'b1;
                  port_e_q   <= 1'b0;
                  state_q    <= IDLE;
                  last_src_q <= SRC_IF;
               end
            end
            BUSY_MEM: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  if (!port_rw_q) mem_rdata_q <= port_do;
                  mem_valid_q <= 1'b1;
                  port_e_q    <= 1'b0;
                  state_q     <= IDLE;
                  last_src_q  <= SRC_MEM;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_valid  = if_valid_q;
   assign if_stall  = if_req & ~if_valid_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_valid = mem_valid_q;
   assign mem_stall = mem_req & ~mem_valid_q;
   assign port_e    = port_e_q;
   assign port_rw   = port_rw_q;
   assign port_size = port_size_q;
   assign port_se   = port_se_q;
   assign port_a    = port_a_q;
   assign port_di   = port_di_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: default-priority arbiter with WAIT_CYCLES=1 plus a WAIT_CYCLES=3 instance.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset, reset3;
   logic        if_req, if_req3;
   logic [8:0]  if_addr;
   logic        mem_req, mem_rw, mem_se;
   logic [1:0]  mem_size;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata, port_do;

   logic [31:0] if_rdata, mem_rdata, port_di;
   logic        if_valid, if_stall, mem_valid, mem_stall, port_e, port_rw, port_se;
   logic [1:0]  port_size;
   logic [8:0]  port_a;

   logic [31:0] if_rdata3, mem_rdata3, port_di3;
   logic        if_valid3, if_stall3, mem_valid3, mem_stall3, port_e3, port_rw3, port_se3;
   logic [1:0]  port_size3;
   logic [8:0]  port_a3;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .mem_req(mem_req), .mem_rw(mem_rw), .mem_size(mem_size), .mem_se(mem_se), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_stall(mem_stall),
      .port_e(port_e), .port_rw(port_rw), .port_size(port_size), .port_se(port_se),
      .port_a(port_a), .port_di(port_di), .port_do(port_do)
   );

   mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .reset(reset3),
      .if_req(if_req3), .if_addr(if_addr), .if_rdata(if_rdata3), .if_valid(if_valid3), .if_stall(if_stall3),
      .mem_req(1'b0), .mem_rw(mem_rw), .mem_size(mem_size), .mem_se(mem_se), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata3), .mem_valid(mem_valid3), .mem_stall(mem_stall3),
      .port_e(port_e3), .port_rw(port_rw3), .port_size(port_size3), .port_se(port_se3),
      .port_a(port_a3), .port_di(port_di3), .port_do(port_do)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int          ng;
      int          both_valid;
      logic        prev_e;
      logic [8:0]  grant_a [4];

      reset = 1'b0; reset3 = 1'b0;
      if_req = 1'b1; if_req3 = 1'b0; if_addr = 9'h004;
      mem_req = 1'b1; mem_rw = 1'b0; mem_size = 2'b01; mem_se = 1'b1;
      mem_addr = 9'h010; mem_wdata = 32'h0; port_do = 32'h0;

      // Reset with both requests high
      step(); step();
      chk("rst_port_e", 32'(port_e), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
      chk("rst_port_a", 32'(port_a), 32'h0);
      chk("rst_port_size", 32'(port_size), 32'd0);
      chk("rst_mem_stall", 32'(mem_stall), 32'd1);
      chk("rst3_port_e", 32'(port_e3), 32'd0);

      // Contention: MEM halfword signed read first, then IF
      reset = 1'b1;
      step();
      chk("cont_c1_port_e", 32'(port_e), 32'd1);
      chk("cont_c1_port_a", 32'(port_a), 32'h010);
      chk("cont_c1_size", 32'(port_size), 32'd1);
      chk("cont_c1_se", 32'(port_se), 32'd1);
      chk("cont_c1_rw", 32'(port_rw), 32'd0);
      chk("cont_c1_if_stall", 32'(if_stall), 32'd1);
      port_do = 32'h0000FF80;
      step();
      chk("cont_c2_mem_valid", 32'(mem_valid), 32'd1);
      chk("cont_c2_mem_rdata", mem_rdata, 32'h0000FF80);
      chk("cont_c2_if_valid", 32'(if_valid), 32'd0);
      chk("cont_c2_port_e", 32'(port_e), 32'd0);
      chk("cont_c2_mem_stall", 32'(mem_stall), 32'd0);
      chk("cont_c2_if_stall", 32'(if_stall), 32'd1);
      port_do = 32'hCAFEF00D;
      step();
      chk("cont_c3_port_e", 32'(port_e), 32'd1);
      chk("cont_c3_port_a", 32'(port_a), 32'h004);
      chk("cont_c3_size", 32'(port_size), 32'd2);
      chk("cont_c3_se", 32'(port_se), 32'd0);
      chk("cont_c3_mem_valid", 32'(mem_valid), 32'd0);
      mem_req = 1'b0;
      #1;
      chk("cont_c3_mem_stall", 32'(mem_stall), 32'd0);
      step();
      chk("cont_c4_if_valid", 32'(if_valid), 32'd1);
      chk("cont_c4_if_rdata", if_rdata, 32'hCAFEF00D);
      chk("cont_c4_if_stall", 32'(if_stall), 32'd0);
      if_req = 1'b0;
      step();
      chk("cont_c5_if_valid", 32'(if_valid), 32'd0);
      chk("cont_c5_port_e", 32'(port_e), 32'd0);

      // Byte store
      mem_req = 1'b1; mem_rw = 1'b1; mem_size = 2'b00; mem_se = 1'b0;
      mem_addr = 9'h021; mem_wdata = 32'h000000AB; port_do = 32'hDEADBEEF;
      #1;
      chk("st_c0_mem_stall", 32'(mem_stall), 32'd1);
      step();
      chk("st_c1_port_e", 32'(port_e), 32'd1);
      chk("st_c1_rw", 32'(port_rw), 32'd1);
      chk("st_c1_size", 32'(port_size), 32'd0);
      chk("st_c1_di", port_di, 32'h000000AB);
      chk("st_c1_a", 32'(port_a), 32'h021);
      step();
      chk("st_c2_mem_valid", 32'(mem_valid), 32'd1);
      chk("st_c2_mem_rdata", mem_rdata, 32'h0000FF80);
      chk("st_c2_port_e", 32'(port_e), 32'd0);
      mem_req = 1'b0; mem_rw = 1'b0; mem_size = 2'b10;
      step();
      chk("st_c3_mem_valid", 32'(mem_valid), 32'd0);

      // IF-only read
      if_req = 1'b1; if_addr = 9'h004; port_do = 32'h2002000A;
      #1;
      chk("if_c0_stall", 32'(if_stall), 32'd1);
      step();
      chk("if_c1_port_e", 32'(port_e), 32'd1);
      chk("if_c1_port_a", 32'(port_a), 32'h004);
      chk("if_c1_size", 32'(port_size), 32'd2);
      chk("if_c1_di", port_di, 32'h0);
      chk("if_c1_stall", 32'(if_stall), 32'd1);
      step();
      chk("if_c2_valid", 32'(if_valid), 32'd1);
      chk("if_c2_rdata", if_rdata, 32'h2002000A);
      chk("if_c2_stall", 32'(if_stall), 32'd0);
      chk("if_c2_mem_valid", 32'(mem_valid), 32'd0);
      if_req = 1'b0;
      step();

      // Both held across four accesses: MEM, IF, MEM, IF
      if_addr = 9'h100; mem_addr = 9'h0AA; mem_rw = 1'b0; mem_size = 2'b10;
      if_req = 1'b1; mem_req = 1'b1; port_do = 32'h55AA55AA;
      ng = 0; both_valid = 0; prev_e = port_e;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         step();
         if (port_e && !prev_e) begin
            grant_a[ng] = port_a;
            ng++;
         end
         if (if_valid && mem_valid) both_valid++;
         prev_e = port_e;
      end
      chk("rr_grant_count", 32'(ng), 32'd4);
      chk("rr_grant0", 32'(grant_a[0]), 32'h0AA);
      chk("rr_grant1", 32'(grant_a[1]), 32'h100);
      chk("rr_grant2", 32'(grant_a[2]), 32'h0AA);
      chk("rr_grant3", 32'(grant_a[3]), 32'h100);
      chk("rr_both_valid", 32'(both_valid), 32'd0);
      if_req = 1'b0; mem_req = 1'b0;
      step(); step(); step();
      chk("rr_drain_port_e", 32'(port_e), 32'd0);

      // WAIT_CYCLES=3: reset during cycle 2 aborts the fetch
      reset3 = 1'b1; if_req3 = 1'b1; if_addr = 9'h008; port_do = 32'h12345678;
      step();
      chk("w3a_c1_port_e", 32'(port_e3), 32'd1);
      step();
      chk("w3a_c2_port_e", 32'(port_e3), 32'd1);
      reset3 = 1'b0;
      step();
      chk("w3a_c3_port_e", 32'(port_e3), 32'd0);
      chk("w3a_c3_if_valid", 32'(if_valid3), 32'd0);
      reset3 = 1'b1; if_req3 = 1'b0;
      step();
      chk("w3a_c4_if_valid", 32'(if_valid3), 32'd0);
      chk("w3a_c4_if_rdata", if_rdata3, 32'h0);

      // WAIT_CYCLES=3 uninterrupted
      if_req3 = 1'b1; port_do = 32'h87654321;
      step();
      chk("w3b_c1_port_e", 32'(port_e3), 32'd1);
      chk("w3b_c1_port_a", 32'(port_a3), 32'h008);
      step();
      chk("w3b_c2_port_e", 32'(port_e3), 32'd1);
      step();
      chk("w3b_c3_port_e", 32'(port_e3), 32'd1);
      chk("w3b_c3_if_valid", 32'(if_valid3), 32'd0);
      chk("w3b_c3_if_stall", 32'(if_stall3), 32'd1);
      step();
      chk("w3b_c4_if_valid", 32'(if_valid3), 32'd1);
      chk("w3b_c4_if_rdata", if_rdata3, 32'h87654321);
      chk("w3b_c4_port_e", 32'(port_e3), 32'd0);
      if_req3 = 1'b0;
      step();
      chk("w3b_c5_if_valid", 32'(if_valid3), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
